// File: rtl/e_parity_check32.sv
// Even-parity checker: registered popcount of a 31-bit word plus pass flag, 1-cycle latency, no backpressure.
// Optional saturating mismatch counter enabled by defining EPARITY_ERRCNT_EN.
module e_parity_check32
`ifdef EPARITY_ERRCNT_EN
#(
    parameter int ERR_CNT_W = 8
)
`endif
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dataValid,
    input  logic [30:0]          data,
    input  logic                 parityBit,
    output logic [4:0]           oneCount,
    output logic                 confirmFlag,
`ifdef EPARITY_ERRCNT_EN
    output logic [ERR_CNT_W-1:0] errorCount,
`endif
    output logic                 resultValid
);

    logic [31:0] word_w;
    logic [1:0]  sum_l1 [16];
    logic [2:0]  sum_l2 [8];
    logic [3:0]  sum_l3 [4];
    logic [4:0]  sum_l4 [2];
    logic [5:0]  sum_l5;

    logic [4:0]  one_count_d, one_count_q;
    logic        confirm_d, confirm_q;
    logic        valid_q;

    // Pad to 32 bits so every tree level halves cleanly.
    assign word_w = {1'b0, data};

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sum_l1[i] = {1'b0, word_w[2*i]} + {1'b0, word_w[2*i+1]};
        end
        for (int i = 0; i < 8; i++) begin
            sum_l2[i] = {1'b0, sum_l1[2*i]} + {1'b0, sum_l1[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            sum_l3[i] = {1'b0, sum_l2[2*i]} + {1'b0, sum_l2[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            sum_l4[i] = {1'b0, sum_l3[2*i]} + {1'b0, sum_l3[2*i+1]};
        end
        sum_l5 = {1'b0, sum_l4[0]} + {1'b0, sum_l4[1]};
    end

    // The padded MSB is always zero, so the sum never exceeds 31.
    assign one_count_d = sum_l5[4:0];
    assign confirm_d   = ~(one_count_d[0] ^ parityBit);

    always_ff @(posedge clk) begin
        if (rst) begin
            one_count_q <= 5'd0;
            confirm_q   <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= dataValid;
            if (dataValid) begin
                one_count_q <= one_count_d;
                confirm_q   <= confirm_d;
            end
        end
    end

`ifdef EPARITY_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (dataValid && !confirm_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign errorCount = err_cnt_q;
`endif

    assign oneCount    = one_count_q;
    assign confirmFlag = confirm_q;
    assign resultValid = valid_q;

endmodule

// File: tb/tb_e_parity_check32.sv
// Directed bench for e_parity_check32; inputs change on falling edges, outputs checked on the next falling edge.
module tb_e_parity_check32;

    logic        clk;
    logic        rst;
    logic        dataValid;
    logic [30:0] data;
    logic        parityBit;
    logic [4:0]  oneCount;
    logic        confirmFlag;
    logic        resultValid;
`ifdef EPARITY_ERRCNT_EN
    logic [1:0]  errorCount;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

`ifdef EPARITY_ERRCNT_EN
    e_parity_check32 #(.ERR_CNT_W(2)) dut (
`else
    e_parity_check32 dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .dataValid   (dataValid),
        .data        (data),
        .parityBit   (parityBit),
        .oneCount    (oneCount),
        .confirmFlag (confirmFlag),
`ifdef EPARITY_ERRCNT_EN
        .errorCount  (errorCount),
`endif
        .resultValid (resultValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [30:0] d, input logic p);
        dataValid = v;
        data      = d;
        parityBit = p;
    endtask

    task automatic expect_out(input string tag, input int cnt, input logic flag, input logic vld);
        chk({tag, ".oneCount"},    32'(cnt),  32'(cnt) == 32'(cnt) ? 32'(cnt) : 32'(0));
        chk({tag, ".confirmFlag"}, 32'(confirmFlag), 32'(flag));
        chk({tag, ".resultValid"}, 32'(resultValid), 32'(vld));
    endtask

    task automatic expect_res(input string tag, input int cnt, input logic flag, input logic vld);
        chk({tag, ".oneCount"},    32'(oneCount),    32'(cnt));
        chk({tag, ".confirmFlag"}, 32'(confirmFlag), 32'(flag));
        chk({tag, ".resultValid"}, 32'(resultValid), 32'(vld));
    endtask

    task automatic expect_err(input string tag, input int e);
`ifdef EPARITY_ERRCNT_EN
        chk({tag, ".errorCount"}, 32'(errorCount), 32'(e));
`endif
    endtask

    initial begin
        // Reset held two cycles with a word offered: it must be dropped.
        rst = 1'b1;
        drive(1'b1, 31'h7FFFFFFF, 1'b1);
        tick();
        tick();
        expect_res("reset", 0, 1'b0, 1'b0);
        expect_err("reset", 0);

        rst = 1'b0;
        drive(1'b1, 31'h2A, 1'b0);
        tick();
        expect_res("fail_word", 3, 1'b0, 1'b1);
        expect_err("fail_word", 1);

        drive(1'b0, 31'h0, 1'b0);
        tick();
        expect_res("fail_word_pulse_end", 3, 1'b0, 1'b0);

        drive(1'b1, 31'h155, 1'b1);
        tick();
        expect_res("pass_word", 5, 1'b1, 1'b1);
        expect_err("pass_word", 1);

        drive(1'b1, 31'h124, 1'b0);
        tick();
        expect_res("b2b0", 3, 1'b0, 1'b1);
        expect_err("b2b0", 2);
        drive(1'b1, 31'h1C34, 1'b0);
        tick();
        expect_res("b2b1", 6, 1'b1, 1'b1);
        drive(1'b1, 31'h0, 1'b0);
        tick();
        expect_res("b2b2", 0, 1'b1, 1'b1);
        drive(1'b1, 31'h7FFFFFFF, 1'b1);
        tick();
        expect_res("b2b3", 31, 1'b1, 1'b1);
        expect_err("b2b3", 2);

        // Idle with changing, failing-looking inputs: outputs must hold.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 31'h2A + 31'(i), 1'b0);
            tick();
            expect_res("hold", 31, 1'b1, 1'b0);
        end
        expect_err("hold", 2);

        drive(1'b1, 31'h40000000, 1'b0);
        tick();
        expect_res("msb_only", 1, 1'b0, 1'b1);
        expect_err("msb_only", 3);

        // Reset and a passing word at the same edge.
        rst = 1'b1;
        drive(1'b1, 31'h155, 1'b1);
        tick();
        expect_res("rst_prio", 0, 1'b0, 1'b0);
        expect_err("rst_prio", 0);
        rst = 1'b0;
        drive(1'b0, 31'h0, 1'b0);
        tick();
        expect_res("rst_prio_after", 0, 1'b0, 1'b0);

        // Five consecutive failing words; counter saturates at 3 when enabled.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 31'h2A, 1'b0);
            tick();
            expect_res("sat_word", 3, 1'b0, 1'b1);
            expect_err("sat", (i < 3) ? i + 1 : 3);
        end
        drive(1'b0, 31'h0, 1'b0);
        tick();
        expect_res("sat_idle", 3, 1'b0, 1'b0);
        expect_err("sat_idle", 3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
